// File: rtl/psk_tx_frame_scheduler_if.sv
// psk_tx_frame_scheduler_if: two byte sources in, framed PSK byte stream out
interface psk_tx_frame_scheduler_if;
  logic [7:0] s0_tdata, s1_tdata, psk_tdata;
  logic s0_tvalid, s0_tlast, s0_tready;
  logic s1_tvalid, s1_tlast, s1_tready;
  logic psk_tvalid, psk_tlast, psk_tuser, psk_tready;
  modport master (
    input s0_tdata, s0_tvalid, s0_tlast, s1_tdata, s1_tvalid, s1_tlast, psk_tready,
    output s0_tready, s1_tready, psk_tdata, psk_tvalid, psk_tlast, psk_tuser
  );
  modport slave (
    output s0_tdata, s0_tvalid, s0_tlast, s1_tdata, s1_tvalid, s1_tlast, psk_tready,
    input s0_tready, s1_tready, psk_tdata, psk_tvalid, psk_tlast, psk_tuser
  );
endinterface

// File: rtl/psk_tx_frame_scheduler.sv
// psk_tx_frame_scheduler: round-robin frame scheduler (preamble, header, payload, gap) feeding the PSK modulator
module psk_tx_frame_scheduler #(
  parameter int PREAMBLE_LEN = 4,
  parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_PAYLOAD = 64
) (
  input logic clk_16d384M,
  input logic rst_16d384M,
  input logic enable,
  psk_tx_frame_scheduler_if.master bus,
  output logic busy,
  output logic frame_src,
  output logic [15:0] frames_sent,
  output logic overflow
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, GAP} state_t;
  state_t state, state_n;
  logic rr;
  logic [3:0] pre_cnt;
  logic [7:0] pay_cnt, gap_cnt, sel_data;
  logic [6:0] seq;
  logic out_load, take, accept, done, grant, forced, gap_end, sel_valid, sel_last;
  always_comb begin
    out_load = !bus.psk_tvalid || bus.psk_tready;
    sel_valid = frame_src ? bus.s1_tvalid : bus.s0_tvalid;
    sel_last = frame_src ? bus.s1_tlast : bus.s0_tlast;
    sel_data = frame_src ? bus.s1_tdata : bus.s0_tdata;
    take = state == PAYLOAD && out_load && !(bus.psk_tvalid && bus.psk_tlast);
    accept = take && sel_valid;
    done = state == PAYLOAD && bus.psk_tvalid && bus.psk_tready && bus.psk_tlast;
    forced = pay_cnt == 8'(MAX_PAYLOAD - 1);
    gap_end = 9'(gap_cnt) + 9'd1 >= 9'(GAP_CYCLES);
    grant = bus.s0_tvalid && bus.s1_tvalid ? rr : bus.s1_tvalid;
    bus.s0_tready = take && !frame_src;
    bus.s1_tready = take && frame_src;
    state_n = state;
    case (state)
      IDLE: state_n = enable && (bus.s0_tvalid || bus.s1_tvalid) ? PREAMBLE : IDLE;
      PREAMBLE: state_n = out_load && pre_cnt == 4'(PREAMBLE_LEN - 1) ? HEADER : PREAMBLE;
      HEADER: state_n = out_load ? PAYLOAD : HEADER;
      PAYLOAD: state_n = done ? GAP : PAYLOAD;
      GAP: state_n = gap_end ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_16d384M) state <= rst_16d384M ? IDLE : state_n;
  assign busy = state != IDLE;
  always_ff @(posedge clk_16d384M) begin
    if (rst_16d384M) begin
      bus.psk_tdata <= '0;
      bus.psk_tvalid <= 1'b0;
      bus.psk_tlast <= 1'b0;
      bus.psk_tuser <= 1'b0;
      frame_src <= 1'b0;
      rr <= 1'b0;
      pre_cnt <= '0;
      pay_cnt <= '0;
      gap_cnt <= '0;
      seq <= '0;
      frames_sent <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pre_cnt <= '0;
          if (state_n == PREAMBLE) begin
            frame_src <= grant;
            rr <= !grant;
          end
        end
        PREAMBLE: if (out_load) begin
          bus.psk_tdata <= PREAMBLE_BYTE;
          bus.psk_tvalid <= 1'b1;
          bus.psk_tuser <= pre_cnt == 4'd0;
          bus.psk_tlast <= 1'b0;
          pre_cnt <= pre_cnt + 4'd1;
        end
        HEADER: if (out_load) begin
          bus.psk_tdata <= {frame_src, seq};
          bus.psk_tvalid <= 1'b1;
          bus.psk_tuser <= 1'b0;
          pay_cnt <= '0;
        end
        PAYLOAD: if (done) begin
          bus.psk_tvalid <= 1'b0;
          bus.psk_tlast <= 1'b0;
          frames_sent <= frames_sent + 16'd1;
          seq <= seq + 7'd1;
          gap_cnt <= '0;
        end else if (accept) begin
          bus.psk_tdata <= sel_data;
          bus.psk_tvalid <= 1'b1;
          bus.psk_tlast <= sel_last || forced;
          overflow <= overflow || (forced && !sel_last);
          pay_cnt <= pay_cnt + 8'd1;
        end else if (out_load) begin
          bus.psk_tvalid <= 1'b0;
        end
        GAP: gap_cnt <= gap_end ? gap_cnt : gap_cnt + 8'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_psk_tx_frame_scheduler.sv
// tb_psk_tx_frame_scheduler: randomized frame-level checks against a queue-based frame model
module tb_psk_tx_frame_scheduler;
  localparam int PLEN = 4;
  localparam int GAP = 16;
  localparam int MAXP = 4;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic busy, frame_src, overflow;
  logic [15:0] frames_sent;
  psk_tx_frame_scheduler_if bus();
  psk_tx_frame_scheduler #(
    .PREAMBLE_LEN(PLEN), .PREAMBLE_BYTE(8'h55), .GAP_CYCLES(GAP), .MAX_PAYLOAD(MAXP)
  ) dut (
    .clk_16d384M(clk), .rst_16d384M(rst), .enable(enable), .bus(bus),
    .busy(busy), .frame_src(frame_src), .frames_sent(frames_sent), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic [8:0] sq[2][$];
  logic [8:0] mq[2][$];
  logic [9:0] rx[$], ex[$];
  int bub[2];
  int rmode = 0, cyc = 0;
  logic mptr, mover;
  logic [6:0] mseq;
  int mframes;
  initial begin
    logic acc[2];
    logic [8:0] h0, h1;
    bub[0] = 0;
    bub[1] = 0;
    {bus.s0_tdata, bus.s0_tvalid, bus.s0_tlast} = '0;
    {bus.s1_tdata, bus.s1_tvalid, bus.s1_tlast} = '0;
    bus.psk_tready = 1'b1;
    forever begin
      @(negedge clk);
      acc[0] = bus.s0_tvalid && bus.s0_tready;
      acc[1] = bus.s1_tvalid && bus.s1_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i] && sq[i].size() > 0) begin
          void'(sq[i].pop_front());
          bub[i] = rmode == 2 ? int'($urandom_range(0, 3)) : 0;
        end else if (bub[i] > 0) bub[i]--;
      end
      cyc++;
      bus.psk_tready = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 3 == 1) : 1'($urandom_range(0, 1));
      h0 = '0;
      h1 = '0;
      if (sq[0].size() > 0) h0 = sq[0][0];
      if (sq[1].size() > 0) h1 = sq[1][0];
      bus.s0_tvalid = sq[0].size() > 0 && bub[0] == 0;
      bus.s0_tdata = h0[7:0];
      bus.s0_tlast = h0[8];
      bus.s1_tvalid = sq[1].size() > 0 && bub[1] == 0;
      bus.s1_tdata = h1[7:0];
      bus.s1_tlast = h1[8];
    end
  end
  initial begin
    logic hold;
    logic [9:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (hold) begin
        checks++;
        if (!bus.psk_tvalid || {bus.psk_tuser, bus.psk_tlast, bus.psk_tdata} !== held) begin
          failures++;
          $display("FAIL hold_stable got valid=%0b word=%h want valid=1 word=%h", bus.psk_tvalid,
                   {bus.psk_tuser, bus.psk_tlast, bus.psk_tdata}, held);
        end
      end
      hold = bus.psk_tvalid && !bus.psk_tready && !rst;
      held = {bus.psk_tuser, bus.psk_tlast, bus.psk_tdata};
      if (bus.psk_tvalid && bus.psk_tready) rx.push_back({bus.psk_tuser, bus.psk_tlast, bus.psk_tdata});
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    sq[0].delete();
    sq[1].delete();
    mq[0].delete();
    mq[1].delete();
    bub[0] = 0;
    bub[1] = 0;
    tick();
    rst = 1'b0;
    rx.delete();
    ex.delete();
    mptr = 1'b0;
    mover = 1'b0;
    mseq = '0;
    mframes = 0;
  endtask
  task automatic push_byte(input int s, input logic [7:0] d, input logic l, input logic to_model);
    sq[s].push_back({l, d});
    if (to_model) mq[s].push_back({l, d});
  endtask
  task automatic model;
    logic g, l;
    logic [8:0] b;
    int n;
    while (mq[0].size() > 0 || mq[1].size() > 0) begin
      g = (mq[0].size() > 0 && mq[1].size() > 0) ? mptr : (mq[1].size() > 0);
      mptr = !g;
      for (int i = 0; i < PLEN; i++) ex.push_back({i == 0, 1'b0, 8'h55});
      ex.push_back({2'b00, g, mseq});
      n = 0;
      do begin
        b = mq[g].pop_front();
        n++;
        l = b[8] || n == MAXP;
        if (n == MAXP && !b[8]) mover = 1'b1;
        ex.push_back({1'b0, l, b[7:0]});
      end while (!l && mq[g].size() > 0);
      mseq++;
      mframes++;
    end
  endtask
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((sq[0].size() > 0 || sq[1].size() > 0 || busy || bus.psk_tvalid) && n < budget);
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL idle_timeout got %0d cycles want below %0d", n, budget);
    end
  endtask
  task automatic test_reset;
    do_reset();
    checks++;
    if ({bus.psk_tvalid, bus.psk_tlast, bus.psk_tuser, bus.psk_tdata, bus.s0_tready, bus.s1_tready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v%0b l%0b u%0b d%h r0%0b r1%0b want all 0", bus.psk_tvalid, bus.psk_tlast,
               bus.psk_tuser, bus.psk_tdata, bus.s0_tready, bus.s1_tready);
    end
    checks++;
    if ({busy, frame_src, overflow, frames_sent} !== '0) begin
      failures++;
      $display("FAIL reset_status got busy%0b src%0b ovf%0b frames%0d want all 0", busy, frame_src, overflow, frames_sent);
    end
  endtask
  task automatic test_single_frame;
    int n;
    rmode = 0;
    enable = 1'b1;
    push_byte(1, 8'hA1, 1'b0, 1'b1);
    push_byte(1, 8'hA2, 1'b0, 1'b1);
    push_byte(1, 8'hA3, 1'b1, 1'b1);
    model();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.psk_tvalid && bus.psk_tready && bus.psk_tlast) && n < 300);
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL single_tlast_timeout got %0d cycles want below 300", n);
    end
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    checks++;
    if (n != GAP) begin
      failures++;
      $display("FAIL single_gap_len got %0d want %0d", n, GAP);
    end
    checks++;
    if (rx.size() != ex.size()) begin
      failures++;
      $display("FAIL single_len got %0d want %0d", rx.size(), ex.size());
    end
    for (int i = 0; i < rx.size() && i < ex.size(); i++) begin
      checks++;
      if (rx[i] !== ex[i]) begin
        failures++;
        $display("FAIL single_byte%0d got %h want %h", i, rx[i], ex[i]);
      end
    end
    checks++;
    if (frames_sent !== 16'(mframes)) begin
      failures++;
      $display("FAIL single_frames got %0d want %0d", frames_sent, mframes);
    end
  endtask
  task automatic test_backpressure;
    rx.delete();
    ex.delete();
    rmode = 1;
    push_byte(1, 8'hA1, 1'b0, 1'b1);
    push_byte(1, 8'hA2, 1'b0, 1'b1);
    push_byte(1, 8'hA3, 1'b1, 1'b1);
    model();
    wait_idle(500);
    rmode = 0;
    checks++;
    if (rx.size() != ex.size()) begin
      failures++;
      $display("FAIL bp_len got %0d want %0d", rx.size(), ex.size());
    end
    for (int i = 0; i < rx.size() && i < ex.size(); i++) begin
      checks++;
      if (rx[i] !== ex[i]) begin
        failures++;
        $display("FAIL bp_byte%0d got %h want %h", i, rx[i], ex[i]);
      end
    end
    checks++;
    if (frames_sent !== 16'(mframes)) begin
      failures++;
      $display("FAIL bp_frames got %0d want %0d", frames_sent, mframes);
    end
  endtask
  task automatic test_arbitration;
    logic [7:0] hdr[4];
    hdr = '{8'h00, 8'h81, 8'h02, 8'h83};
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 2; s++) begin
        push_byte(s, 8'(16 * s + 2 * p), 1'b0, 1'b1);
        push_byte(s, 8'(16 * s + 2 * p + 1), 1'b1, 1'b1);
      end
    model();
    wait_idle(1000);
    checks++;
    if (rx.size() != ex.size()) begin
      failures++;
      $display("FAIL arb_len got %0d want %0d", rx.size(), ex.size());
    end
    for (int i = 0; i < rx.size() && i < ex.size(); i++) begin
      checks++;
      if (rx[i] !== ex[i]) begin
        failures++;
        $display("FAIL arb_byte%0d got %h want %h", i, rx[i], ex[i]);
      end
    end
    for (int k = 0; k < 4 && 4 + 7 * k < rx.size(); k++) begin
      checks++;
      if (rx[4 + 7 * k][7:0] !== hdr[k]) begin
        failures++;
        $display("FAIL arb_header%0d got %h want %h", k, rx[4 + 7 * k][7:0], hdr[k]);
      end
    end
  endtask
  task automatic test_forced_end;
    do_reset();
    for (int i = 1; i <= 6; i++) push_byte(0, 8'(8'hB0 + i), i == 6, 1'b1);
    model();
    wait_idle(1000);
    checks++;
    if (rx.size() != ex.size()) begin
      failures++;
      $display("FAIL forced_len got %0d want %0d", rx.size(), ex.size());
    end
    for (int i = 0; i < rx.size() && i < ex.size(); i++) begin
      checks++;
      if (rx[i] !== ex[i]) begin
        failures++;
        $display("FAIL forced_byte%0d got %h want %h", i, rx[i], ex[i]);
      end
    end
    checks++;
    if (overflow !== mover || frames_sent !== 16'(mframes)) begin
      failures++;
      $display("FAIL forced_status got ovf%0b frames%0d want ovf%0b frames%0d", overflow, frames_sent, mover, mframes);
    end
  endtask
  task automatic test_reset_mid_payload;
    int n;
    rx.delete();
    ex.delete();
    for (int i = 1; i <= 4; i++) push_byte(1, 8'(8'hC0 + i), i == 4, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.s1_tvalid && bus.s1_tready) && n < 300);
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL rstmid_payload_timeout got %0d cycles want below 300", n);
    end
    tick();
    do_reset();
    checks++;
    if ({bus.psk_tvalid, bus.psk_tlast, bus.psk_tuser, bus.psk_tdata, busy, frame_src, overflow, frames_sent} !== '0) begin
      failures++;
      $display("FAIL rstmid_zero got v%0b l%0b u%0b d%h busy%0b src%0b ovf%0b frames%0d want all 0", bus.psk_tvalid,
               bus.psk_tlast, bus.psk_tuser, bus.psk_tdata, busy, frame_src, overflow, frames_sent);
    end
    push_byte(0, 8'hD1, 1'b0, 1'b1);
    push_byte(0, 8'hD2, 1'b1, 1'b1);
    model();
    wait_idle(500);
    checks++;
    if (rx.size() != ex.size()) begin
      failures++;
      $display("FAIL rstmid_len got %0d want %0d", rx.size(), ex.size());
    end
    for (int i = 0; i < rx.size() && i < ex.size(); i++) begin
      checks++;
      if (rx[i] !== ex[i]) begin
        failures++;
        $display("FAIL rstmid_byte%0d got %h want %h", i, rx[i], ex[i]);
      end
    end
    if (rx.size() > 4) begin
      checks++;
      if (rx[4][7:0] !== 8'h00) begin
        failures++;
        $display("FAIL rstmid_header got %h want 00", rx[4][7:0]);
      end
    end
  endtask
  task automatic test_enable_drop;
    int n;
    do_reset();
    enable = 1'b1;
    push_byte(0, 8'hE1, 1'b0, 1'b1);
    push_byte(0, 8'hE2, 1'b1, 1'b1);
    push_byte(0, 8'hE3, 1'b0, 1'b0);
    push_byte(0, 8'hE4, 1'b1, 1'b0);
    model();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.psk_tvalid && bus.psk_tuser) && n < 100);
    tick();
    enable = 1'b0;
    n = 0;
    while (frames_sent == 16'd0 && n < 300) begin
      tick();
      n++;
    end
    repeat (GAP + 20) tick();
    checks++;
    if (busy !== 1'b0 || frames_sent !== 16'd1 || bus.s0_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL endrop_status got busy%0b frames%0d s0v%0b want busy0 frames1 s0v1", busy, frames_sent, bus.s0_tvalid);
    end
    checks++;
    if (rx.size() != ex.size()) begin
      failures++;
      $display("FAIL endrop_len got %0d want %0d", rx.size(), ex.size());
    end
    for (int i = 0; i < rx.size() && i < ex.size(); i++) begin
      checks++;
      if (rx[i] !== ex[i]) begin
        failures++;
        $display("FAIL endrop_byte%0d got %h want %h", i, rx[i], ex[i]);
      end
    end
  endtask
  task automatic test_random;
    int np, len;
    do_reset();
    enable = 1'b1;
    rmode = 2;
    for (int s = 0; s < 2; s++) begin
      np = $urandom_range(2, 5);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 7);
        for (int i = 0; i < len; i++) push_byte(s, 8'($urandom), i == len - 1, 1'b1);
      end
    end
    model();
    wait_idle(20000);
    rmode = 0;
    checks++;
    if (rx.size() != ex.size()) begin
      failures++;
      $display("FAIL rand_len got %0d want %0d", rx.size(), ex.size());
    end
    for (int i = 0; i < rx.size() && i < ex.size(); i++) begin
      checks++;
      if (rx[i] !== ex[i]) begin
        failures++;
        $display("FAIL rand_byte%0d got %h want %h", i, rx[i], ex[i]);
      end
    end
    checks++;
    if (frames_sent !== 16'(mframes) || overflow !== mover) begin
      failures++;
      $display("FAIL rand_status got frames%0d ovf%0b want frames%0d ovf%0b", frames_sent, overflow, mframes, mover);
    end
  endtask
  initial begin
    repeat (2) tick();
    test_reset();
    test_single_frame();
    test_backpressure();
    test_arbitration();
    test_forced_end();
    test_reset_mid_payload();
    test_enable_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/psk_tx_frame_scheduler.md
Name: psk_tx_frame_scheduler

Overview:
- Shares the PSK modulator's byte-stream input between two AXI-stream byte sources: source 0 (control/beacon) and source 1 (payload data).
- Schedules whole frames, not bytes. Each frame is a sync preamble, then one header byte, then the granted source's payload, then a guard gap.
- Drives psk_tdata, psk_tvalid, psk_tlast and psk_tuser, and honours psk_tready, in the modulator's symbol-rate domain.

Parameters:
- PREAMBLE_LEN, 4: number of preamble bytes per frame (1..15).
- PREAMBLE_BYTE, 8'h55: value of every preamble byte.
- GAP_CYCLES, 16: idle clocks after each frame ends (0..255).
- MAX_PAYLOAD, 64: maximum payload bytes per frame before a forced end (1..255).

Ports:
- clk_16d384M  in  1  sole clock.
- rst_16d384M  in  1  synchronous active-high reset.
- enable  in  1  1 = new frames may start.
- s0_tdata  in  8  source 0 byte.
- s0_tvalid  in  1  source 0 valid.
- s0_tlast  in  1  source 0 last byte of its frame.
- s0_tready  out  1  source 0 byte accepted when high together with s0_tvalid.
- s1_tdata, s1_tvalid, s1_tlast, s1_tready: same as source 0, for source 1.
- psk_tdata  out  8  byte to modulator.
- psk_tvalid  out  1  output valid.
- psk_tlast  out  1  last byte of frame.
- psk_tuser  out  1  first byte of frame (first preamble byte).
- psk_tready  in  1  modulator accepts byte.
- busy  out  1  high in any state other than IDLE.
- frame_src  out  1  source granted for the current or most recent frame.
- frames_sent  out  16  count of completed frames, wraps at 65535 -> 0.
- overflow  out  1  sticky; set on a forced frame end; cleared only by reset.

Behaviour:
- Reset (synchronous, takes effect on the next clock edge):
  - psk_tvalid, psk_tlast, psk_tuser, psk_tdata = 0.
  - s0_tready, s1_tready = 0; busy = 0; frame_src = 0; frames_sent = 0; overflow = 0.
  - State = IDLE; round-robin pointer = 0 (source 0 has priority at the first tie).
  - Reset mid-frame aborts the frame with no resume; any byte the modulator has not yet taken is discarded.
- Output register:
  - One registered stage: out_load = !psk_tvalid || psk_tready.
  - Once psk_tvalid is high, psk_tdata, psk_tlast and psk_tuser hold until psk_tready is sampled high.
- States:
  - IDLE:
    - If enable and at least one sN_tvalid, grant a source and go to PREAMBLE.
    - Both valid: grant the source that is not the last one granted. One valid: grant it.
    - frame_src and the round-robin pointer update at the grant.
  - PREAMBLE:
    - Load PREAMBLE_LEN bytes of PREAMBLE_BYTE, one per out_load.
    - psk_tuser = 1 on the first preamble byte only.
    - After the last preamble byte, go to HEADER.
  - HEADER:
    - Load one byte: {frame_src, seq[6:0]}. seq is a 7-bit per-scheduler frame sequence number that starts at 0 and increments when a frame completes.
    - Then go to PAYLOAD.
  - PAYLOAD:
    - Granted sN_tready = out_load; the other source's tready = 0.
    - A byte accepted on cycle N appears on psk_tdata at cycle N+1.
    - psk_tlast = 1 on the byte where sN_tlast = 1, or on byte number MAX_PAYLOAD.
    - The MAX_PAYLOAD case is a forced end: overflow is set, and the source's remaining bytes start a new frame later.
    - The frame is complete when the psk_tlast byte is accepted by the modulator (psk_tvalid && psk_tready && psk_tlast).
    - At completion: frames_sent increments, seq increments, and the state goes to GAP.
  - GAP:
    - Count GAP_CYCLES clocks with psk_tvalid = 0, then return to IDLE.
    - GAP_CYCLES = 0 returns to IDLE on the next clock.
- Source handling:
  - sN_tready is never high outside PAYLOAD and is never high for the non-granted source.
  - A source whose tvalid drops mid-payload stalls the frame; psk_tvalid = 0 until it resumes. There is no timeout.
- enable:
  - Sampled only in IDLE.
  - Deasserting enable mid-frame lets the frame and its gap finish, then the block stays in IDLE.
- Arithmetic:
  - Preamble, payload and gap counters saturate at their terminal value and reset at each frame start.

Test Plan:
- Single frame:
  - Stimulus: PREAMBLE_LEN=4, GAP=16; s1 sends 3 bytes A1 A2 A3 (tlast on A3); psk_tready held 1.
  - Required: output 55 55 55 55 80 A1 A2 A3; tuser only on the first byte; tlast only on A3; frames_sent=1; busy low 16 cycles after A3 is accepted.
- Back-pressure:
  - Stimulus: same frame as above; psk_tready toggles 1,0,0,1,...
  - Required: output bytes are held stable while tready=0; the byte sequence is identical to the single-frame case; no byte is lost or duplicated.
- Arbitration:
  - Stimulus: s0 and s1 both have 2-byte frames continuously pending.
  - Required: grants alternate s0, s1, s0, s1; header bytes are 00, 81, 02, 83.
- Forced end:
  - Stimulus: MAX_PAYLOAD=4; s0 sends 6 bytes with tlast on byte 6.
  - Required: frame 1 carries bytes 1-4 with tlast on byte 4; overflow=1; after the gap, frame 2 carries bytes 5-6.
- Reset mid-payload:
  - Stimulus: assert rst_16d384M one cycle during PAYLOAD.
  - Required: next cycle all outputs are 0, frames_sent=0, state IDLE; a new frame starts afterwards with header seq 0.
- Enable drop:
  - Stimulus: deassert enable during PREAMBLE.
  - Required: the frame completes normally, the gap elapses, and no new grant occurs even though s0_tvalid=1.
